// File: rtl/seq_alu.sv
// Registered ALU with C/Z/N/V flags and a WIDTH-cycle shift-add multiplier.
// Every op completes through a one-cycle DONE state. F and the flags change only on completion.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] F,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     f_q, f_d;
    logic                 c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_f;
    logic                 alu_c, alu_v;
    logic [2*WIDTH-1:0]   step_prod;
    logic                 accept;

    // Single-cycle result, computed straight from the inputs and registered on the accept edge.
    always_comb begin
        sum   = '0;
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (S)
            OP_ADD: begin
                sum   = {1'b0, A} + {1'b0, B};
                alu_f = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_f[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, A} - {1'b0, B};
                alu_f = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_f[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_f = A & B;
            OP_NOT:  alu_f = ~A;
            OP_OR:   alu_f = A | B;
            OP_XOR:  alu_f = A ^ B;
            OP_SHL:  alu_f = A << B;  // a shift of WIDTH or more clears every bit
            default: alu_f = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        c_d       = c_q;
        z_d       = z_q;
        n_d       = n_q;
        v_d       = v_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        accept    = start && (state_q != MUL);
        step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (S == OP_MUL) begin
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        f_d     = alu_f;
                        c_d     = alu_c;
                        v_d     = alu_v;
                        z_d     = (alu_f == '0);
                        n_d     = alu_f[WIDTH-1];
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                // One partial product per cycle: the multiplicand moves left and the multiplier moves right.
                prod_d   = step_prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    f_d     = step_prod[WIDTH-1:0];
                    c_d     = |step_prod[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    z_d     = (step_prod[WIDTH-1:0] == '0);
                    n_d     = step_prod[WIDTH-1];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            f_q      <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign F    = f_q;
    assign C    = c_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign V    = v_q;
    assign busy = (state_q == MUL);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=4). Stimulus pushes the expected result, latency and busy length.
// A negedge monitor pops and checks an entry on every done pulse.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] S = '0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [3:0] F;
    logic       C, Z, N, V, busy, done;

    seq_alu #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .S(S), .A(A), .B(B),
        .F(F), .C(C), .Z(Z), .N(N), .V(V), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] f;
        logic       c, z, n, v;
        int         acc;
        int         lat;
        int         bcy;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: {F,C,Z,N,V} is compared as one 8-bit value.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy === 1'b1) busy_run++;
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got F=%0h with no pending op (cycle %0d)", F, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("result_FCZNV", 32'({F, C, Z, N, V}), 32'({e.f, e.c, e.z, e.n, e.v}));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_run), 32'(e.bcy));
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ef, input logic ec, input logic ez,
                         input logic en, input logic ev, input bit push);
        exp_t e;
        start = 1'b1; S = op; A = a; B = b;
        if (push) begin
            e.f = ef; e.c = ec; e.z = ez; e.n = en; e.v = ev;
            e.acc = cyc;
            e.lat = (op == 3'b111) ? 5 : 1;
            e.bcy = (op == 3'b111) ? 4 : 0;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        // Scramble the operands so any late sampling corrupts the result
        S = 3'($urandom); A = 4'($urandom); B = 4'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ef, input logic ec, input logic ez,
                       input logic en, input logic ev);
        issue(op, a, b, ef, ec, ez, en, ev, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({F, C, Z, N, V, busy, done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //   op      A     B     F     C     Z     N     V
        run(3'b000, 4'h7, 4'h9, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3'b001, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0);
        run(3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);

        // MUL 5*3 with a start during busy that must be ignored
        issue(3'b111, 4'h5, 4'h3, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; S = 3'b000; A = 4'h1; B = 4'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("F_hold_after_ignored_start", 32'(F), 32'hF);

        run(3'b111, 4'h6, 4'h5, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0);
        run(3'b011, 4'h0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        run(3'b110, 4'h3, 4'h2, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
        run(3'b110, 4'h3, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);
        run(3'b100, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        run(3'b001, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(3'b111, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3'b111, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back: XOR is accepted in AND's DONE cycle
        issue(3'b010, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(3'b101, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset in the middle of MUL F*F: no completion is expected
        issue(3'b111, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_abort_mul", 32'({F, C, Z, N, V, busy, done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(3'b000, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
